// File: rtl/cmp42_pkg.sv
// Shared definitions for the 4:2 compressor row: legal pipeline depths,
// the default constant-one lane mask of the 16x16 Booth tree, and the per-lane result type.
package cmp42_pkg;

   localparam int STAGES_MIN = 1;
   localparam int STAGES_MAX = 2;

   // Lanes that absorb the Booth sign-extension ones in the 16x16 tree
   localparam logic [15:0] BOOTH16_ONE_MASK = 16'hAAAA;

   typedef struct packed {
      logic sum;
      logic carry;
   } lane_res_t;

   function automatic bit stages_legal(input int stages);
      return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
   endfunction

endpackage

// File: rtl/compressor_3_2.sv
// Full adder used as a 3:2 counter in both compressor layers.
module compressor_3_2 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/compressor_4_2_lane.sv
// One bit of the 4:2 row. Layer 1 and layer 2 have separate ports so the row
// can place a register between them; ONE_BIT forces the c input to constant 1.
module compressor_4_2_lane
   import cmp42_pkg::*;
#(
   parameter bit ONE_BIT = 1'b0
) (
   input  logic      a,
   input  logic      b,
   input  logic      c,
   output logic      s1,
   output logic      h,
   input  logic      l2_s1,
   input  logic      l2_d,
   input  logic      l2_ci,
   output lane_res_t res
);

   logic c_eff;
   logic sum_bit;
   logic carry_bit;

   assign c_eff = ONE_BIT ? 1'b1 : c;

   compressor_3_2 u_layer1 (
      .a  (a),
      .b  (b),
      .c  (c_eff),
      .s  (s1),
      .co (h)
   );

   compressor_3_2 u_layer2 (
      .a  (l2_s1),
      .b  (l2_d),
      .c  (l2_ci),
      .s  (sum_bit),
      .co (carry_bit)
   );

   assign res.sum   = sum_bit;
   assign res.carry = carry_bit;

endmodule

// File: rtl/compressor_4_2_row_pipe.sv
// WIDTH-bit row of 4:2 compressors with a STAGES-deep valid/ready pipeline.
// Optional invariant checker on chk_err is built only when CMP42_ROW_CHECK_EN is defined.
module compressor_4_2_row_pipe
   import cmp42_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] ONE_MASK = '0,
   parameter int               STAGES   = 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic             cout
`ifdef CMP42_ROW_CHECK_EN
   ,
   output logic             chk_err
`endif
);

   if (!stages_legal(STAGES)) begin : g_bad_stages
      $error("compressor_4_2_row_pipe: STAGES must be 1 or 2");
   end
   if (WIDTH < 2) begin : g_bad_width
      $error("compressor_4_2_row_pipe: WIDTH must be at least 2");
   end

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] h;
   logic [WIDTH-1:0] ci_l1;
   logic [WIDTH-1:0] l2_s1;
   logic [WIDTH-1:0] l2_d;
   logic [WIDTH-1:0] l2_ci;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] carry_next;
   logic             cout_l2;
   logic             load_in;
   logic             load_out;
   logic             out_v_reg;
   logic             cout_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH-1:0] carry_reg;

   // Horizontal chain: each lane's layer-1 carry feeds layer 2 of the lane above
   assign ci_l1 = {h[WIDTH-2:0], cin};

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      lane_res_t res;

      compressor_4_2_lane #(
         .ONE_BIT (ONE_MASK[gi])
      ) u_lane (
         .a     (a[gi]),
         .b     (b[gi]),
         .c     (c[gi]),
         .s1    (s1[gi]),
         .h     (h[gi]),
         .l2_s1 (l2_s1[gi]),
         .l2_d  (l2_d[gi]),
         .l2_ci (l2_ci[gi]),
         .res   (res)
      );

      assign sum_next[gi]   = res.sum;
      assign carry_next[gi] = res.carry;
   end

   assign load_in = in_valid & in_ready;

   if (STAGES == 1) begin : g_one
      assign l2_s1    = s1;
      assign l2_d     = d;
      assign l2_ci    = ci_l1;
      assign cout_l2  = h[WIDTH-1];
      assign in_ready = ~out_v_reg | out_ready;
      assign load_out = load_in;
   end else begin : g_two
      logic             v0_reg;
      logic             cout0_reg;
      logic             ready0_next;
      logic [WIDTH-1:0] s1_reg;
      logic [WIDTH-1:0] d_reg;
      logic [WIDTH-1:0] ci_reg;

      assign ready0_next = ~out_v_reg | out_ready;
      assign in_ready    = ~v0_reg | ready0_next;
      assign load_out    = v0_reg & ready0_next;

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            v0_reg    <= 1'b0;
            cout0_reg <= 1'b0;
            s1_reg    <= '0;
            d_reg     <= '0;
            ci_reg    <= '0;
         end else begin
            if (load_in) begin
               v0_reg    <= 1'b1;
               cout0_reg <= h[WIDTH-1];
               s1_reg    <= s1;
               d_reg     <= d;
               ci_reg    <= ci_l1;
            end else if (load_out) begin
               v0_reg <= 1'b0;
            end
         end
      end

      assign l2_s1   = s1_reg;
      assign l2_d    = d_reg;
      assign l2_ci   = ci_reg;
      assign cout_l2 = cout0_reg;
   end

   // Result register: only loads on handoff, so a stalled beat stays put
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         out_v_reg <= 1'b0;
         cout_reg  <= 1'b0;
         sum_reg   <= '0;
         carry_reg <= '0;
      end else begin
         if (load_out) begin
            out_v_reg <= 1'b1;
            cout_reg  <= cout_l2;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
         end else if (out_ready) begin
            out_v_reg <= 1'b0;
         end
      end
   end

   assign out_valid = out_v_reg;
   assign sum       = sum_reg;
   assign carry     = carry_reg;
   assign cout      = cout_reg;

`ifdef CMP42_ROW_CHECK_EN
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] op_c;
   logic [WIDTH-1:0] op_d;
   logic             op_cin;
   logic [WIDTH:0]   lhs;
   logic [WIDTH:0]   rhs;
   logic             chk_reg;

   if (STAGES == 1) begin : g_op_direct
      assign op_a   = a;
      assign op_b   = b;
      assign op_c   = c | ONE_MASK;
      assign op_d   = d;
      assign op_cin = cin;
   end else begin : g_op_pipe
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_c   <= '0;
            op_d   <= '0;
            op_cin <= 1'b0;
         end else if (load_in) begin
            op_a   <= a;
            op_b   <= b;
            op_c   <= c | ONE_MASK;
            op_d   <= d;
            op_cin <= cin;
         end
      end
   end

   // Both sides wrap naturally at WIDTH+1 bits, which is the invariant's modulus
   assign lhs = {1'b0, op_a} + {1'b0, op_b} + {1'b0, op_c} + {1'b0, op_d}
              + {{WIDTH{1'b0}}, op_cin};
   assign rhs = {1'b0, sum_next} + {carry_next, 1'b0} + {cout_l2, {WIDTH{1'b0}}};

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         chk_reg <= 1'b0;
      end else if (load_out) begin
         chk_reg <= (lhs != rhs);
      end else if (out_ready) begin
         chk_reg <= 1'b0;
      end
   end

   assign chk_err = chk_reg;
`endif

endmodule
